miss_tag_allocator: RTL and testbench

//  Cache miss front end for the MSHR tag free-list FIFO.

---
 rtl/miss_tag_allocator_if.sv | 61 ++++++
 rtl/miss_tag_allocator.sv | 166 ++++++++++++++++
 tb/tb_miss_tag_allocator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/miss_tag_allocator_if.sv
// miss_tag_allocator_if
//   Handshake bundle between the miss tag allocator and its neighbours:
//   the cache miss and fill channels, the MSHR tag free list, and the
//   memory request and response channels.
//   master : allocator side (drives miss_ready, pop/push, mem_req_*,
//            mem_rsp_ready, fill_*, outstanding, err_unknown_tag)
//   slave  : environment side (cache, free list, memory)
//   MISS_ALLOC_STATS_EN adds the alloc_count / stall_count outputs.
interface miss_tag_allocator_if #(
    parameter int tag_bits  = 3,
    parameter int addr_bits = 32
);
    logic                 enable;
    logic                 miss_valid;
    logic [addr_bits-1:0] miss_addr;
    logic                 miss_ready;
    logic [tag_bits-1:0]  free_tag;
    logic                 free_tag_valid;
    logic                 pop;
    logic                 push;
    logic [tag_bits-1:0]  push_tag;
    logic                 mem_req_valid;
    logic [addr_bits-1:0] mem_req_addr;
    logic [tag_bits-1:0]  mem_req_tag;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    logic [tag_bits-1:0]  mem_rsp_tag;
    logic                 mem_rsp_ready;
    logic                 fill_valid;
    logic [addr_bits-1:0] fill_addr;
    logic [tag_bits-1:0]  fill_tag;
    logic                 fill_ready;
    logic [tag_bits:0]    outstanding;
    logic                 err_unknown_tag;
`ifdef MISS_ALLOC_STATS_EN
    logic [31:0]          alloc_count;
    logic [31:0]          stall_count;
`endif

    modport master (
        input  enable, miss_valid, miss_addr, free_tag, free_tag_valid,
               mem_req_ready, mem_rsp_valid, mem_rsp_tag, fill_ready,
        output miss_ready, pop, push, push_tag, mem_req_valid, mem_req_addr,
               mem_req_tag, mem_rsp_ready, fill_valid, fill_addr, fill_tag,
               outstanding, err_unknown_tag
`ifdef MISS_ALLOC_STATS_EN
        , output alloc_count, stall_count
`endif
    );

    modport slave (
        output enable, miss_valid, miss_addr, free_tag, free_tag_valid,
               mem_req_ready, mem_rsp_valid, mem_rsp_tag, fill_ready,
        input  miss_ready, pop, push, push_tag, mem_req_valid, mem_req_addr,
               mem_req_tag, mem_rsp_ready, fill_valid, fill_addr, fill_tag,
               outstanding, err_unknown_tag
`ifdef MISS_ALLOC_STATS_EN
        , input alloc_count, stall_count
`endif
    );
endinterface

// File: rtl/miss_tag_allocator.sv
// miss_tag_allocator
//   Cache miss front end for the MSHR tag free list. Each accepted miss pops
//   the free-list head tag, records the miss address in a tag-indexed table
//   and issues a tagged memory request one cycle later. Each memory response
//   is turned into a fill to the cache, after which the tag is pushed back to
//   the free list.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : miss_tag_allocator_if.master (miss, free list, mem req/rsp,
//            fill, outstanding count, sticky unknown-tag error)
// Optional feature
//   MISS_ALLOC_STATS_EN : adds alloc_count (accepted misses) and stall_count
//   (cycles with enable & miss_valid & !miss_ready); both wrap at 2**32.
module miss_tag_allocator #(
    parameter int tag_bits  = 3,
    parameter int addr_bits = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    miss_tag_allocator_if.master  bus
);
    localparam int NTAGS = 1 << tag_bits;
    localparam logic [tag_bits:0] ONE = {{tag_bits{1'b0}}, 1'b1};

    localparam logic [1:0] RSP_IDLE    = 2'd0;
    localparam logic [1:0] RSP_FILL    = 2'd1;
    localparam logic [1:0] RSP_RELEASE = 2'd2;

    logic [1:0]           r_state;
    logic [tag_bits-1:0]  r_tag;
    logic [NTAGS-1:0]     r_pend;
    logic [addr_bits-1:0] r_table [NTAGS];
    logic                 r_req_valid;
    logic [addr_bits-1:0] r_req_addr;
    logic [tag_bits-1:0]  r_req_tag;
    logic [tag_bits:0]    r_outstanding;
    logic                 r_err;

    logic w_miss_ready;
    logic w_accept;
    logic w_rsp_ready;
    logic w_rsp_accept;
    logic w_fill;
    logic w_release;

    // reset term keeps the combinational handshakes at 0 while in reset,
    // even though the free list may already present a valid head.
    assign w_miss_ready = reset & bus.enable & bus.free_tag_valid &
                          (~r_req_valid | bus.mem_req_ready);
    assign w_accept     = bus.miss_valid & w_miss_ready;
    assign w_rsp_ready  = reset & bus.enable & (r_state == RSP_IDLE);
    assign w_rsp_accept = bus.mem_rsp_valid & w_rsp_ready;
    // fill stays visible during a stall; only the transition needs enable
    assign w_fill       = (r_state == RSP_FILL);
    assign w_release    = reset & bus.enable & (r_state == RSP_RELEASE);

    assign bus.miss_ready      = w_miss_ready;
    assign bus.pop             = w_accept;
    assign bus.mem_rsp_ready   = w_rsp_ready;
    assign bus.push            = w_release;
    assign bus.push_tag        = w_release ? r_tag : '0;
    assign bus.fill_valid      = w_fill;
    assign bus.fill_addr       = w_fill ? r_table[r_tag] : '0;
    assign bus.fill_tag        = w_fill ? r_tag : '0;
    assign bus.mem_req_valid   = r_req_valid;
    assign bus.mem_req_addr    = r_req_addr;
    assign bus.mem_req_tag     = r_req_tag;
    assign bus.outstanding     = r_outstanding;
    assign bus.err_unknown_tag = r_err;

    // Release clears the serviced tag while an accept may set a different
    // one in the same cycle; the accepted tag is never the one being released
    // because it only re-enters the free list after the push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            if (w_release) r_pend[r_tag] <= 1'b0;
            if (w_accept)  r_pend[bus.free_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAGS; i++) r_table[i] <= '0;
        end else if (w_accept) begin
            r_table[bus.free_tag] <= bus.miss_addr;
        end
    end

    // Request register: a new accept may replace a draining request in the
    // same cycle; addr/tag hold after a plain drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_tag   <= '0;
        end else if (bus.enable) begin
            if (w_accept) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= bus.miss_addr;
                r_req_tag   <= bus.free_tag;
            end else if (bus.mem_req_ready) begin
                r_req_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_release})
                2'b10:   r_outstanding <= r_outstanding + ONE;
                2'b01:   r_outstanding <= r_outstanding - ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Response path: a response for a tag that is not pending is dropped
    // with a sticky error and no push, so the free list is never corrupted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RSP_IDLE;
            r_tag   <= '0;
            r_err   <= 1'b0;
        end else if (bus.enable) begin
            case (r_state)
                RSP_IDLE: begin
                    if (w_rsp_accept) begin
                        if (r_pend[bus.mem_rsp_tag]) begin
                            r_tag   <= bus.mem_rsp_tag;
                            r_state <= RSP_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RSP_FILL:    if (bus.fill_ready) r_state <= RSP_RELEASE;
                RSP_RELEASE: r_state <= RSP_IDLE;
                default:     r_state <= RSP_IDLE;
            endcase
        end
    end

`ifdef MISS_ALLOC_STATS_EN
    logic [31:0] r_alloc_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alloc_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept) r_alloc_count <= r_alloc_count + 32'd1;
            if (bus.enable & bus.miss_valid & ~w_miss_ready)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.alloc_count = r_alloc_count;
    assign bus.stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_miss_tag_allocator.sv
module tb_miss_tag_allocator;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    miss_tag_allocator_if #(.tag_bits(3), .addr_bits(32)) bus();
    miss_tag_allocator #(.tag_bits(3), .addr_bits(32)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic en, mv; logic [31:0] ma; logic mrr, rv; logic [2:0] rt; logic fr;
    } in_t;

    typedef struct packed {
        logic mr, pop, push; logic [2:0] ptag;
        logic rqv; logic [2:0] rqt; logic [31:0] rqa;
        logic rsr, fv; logic [2:0] ftag; logic [31:0] fa;
        logic [3:0] outs; logic err;
    } obs_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] fl[$];   // free list FIFO paired with the DUT
    in_t  tin[$];
    obs_t tex[$];

    function automatic in_t I(logic en, logic mv, logic [31:0] ma, logic mrr,
                              logic rv, logic [2:0] rt, logic fr);
        I = '{en, mv, ma, mrr, rv, rt, fr};
    endfunction

    function automatic obs_t O(logic mr, logic pop, logic push, logic [2:0] ptag,
                               logic rqv, logic [2:0] rqt, logic [31:0] rqa,
                               logic rsr, logic fv, logic [2:0] ftag, logic [31:0] fa,
                               logic [3:0] outs, logic err);
        O = '{mr, pop, push, ptag, rqv, rqt, rqa, rsr, fv, ftag, fa, outs, err};
    endfunction

    function automatic obs_t observe();
        observe = '{bus.miss_ready, bus.pop, bus.push, bus.push_tag,
                    bus.mem_req_valid, bus.mem_req_tag, bus.mem_req_addr,
                    bus.mem_rsp_ready, bus.fill_valid, bus.fill_tag, bus.fill_addr,
                    bus.outstanding, bus.err_unknown_tag};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(in_t v);
        bus.enable        = v.en;
        bus.miss_valid    = v.mv;
        bus.miss_addr     = v.ma;
        bus.mem_req_ready = v.mrr;
        bus.mem_rsp_valid = v.rv;
        bus.mem_rsp_tag   = v.rt;
        bus.fill_ready    = v.fr;
        bus.free_tag_valid = (fl.size() > 0);
        bus.free_tag       = (fl.size() > 0) ? fl[0] : 3'd0;
    endtask

    // advance one clock, letting the free list react to pop/push
    task automatic cycle();
        logic p, q;
        logic [2:0] pt;
        p = bus.pop; q = bus.push; pt = bus.push_tag;
        @(posedge clk);
        if (p) void'(fl.pop_front());
        if (q) fl.push_back(pt);
        @(negedge clk);
    endtask

    task automatic step(string nm, in_t v, obs_t e);
        drive(v);
        #1;
        chk(nm, observe(), e);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fl = {};
        for (int t = 0; t < 8; t++) fl.push_back(3'(t));
        drive(I(1, 1, 32'h0, 1, 1, 3'd0, 1));
        #1;
        chk("reset_outputs", observe(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // behavioural reference for the random phase
    bit          m_pend[8];
    logic [31:0] m_addr[8];
    logic [2:0]  memq[$];
    logic        m_rqv;
    logic [2:0]  m_rqt;
    logic [31:0] m_rqa;
    int          m_ph;     // 0 waiting for response, 1 filling, 2 releasing
    logic [2:0]  m_cur;
    int          m_outs;
    logic        m_err;
    int          m_alloc, m_stall;

    initial begin
        in_t  v;
        obs_t e;
        do_reset();

        // directed table: fill all eight tags, starve, fill/release tag 3,
        // then a held request through a stall
        tin.push_back(I(1,0,32'h0,1,0,0,0));    tex.push_back(O(1,0,0,0, 0,0,32'h0,    1,0,0,32'h0, 0,0));
        tin.push_back(I(1,1,32'h1000,1,0,0,0)); tex.push_back(O(1,1,0,0, 0,0,32'h0,    1,0,0,32'h0, 0,0));
        tin.push_back(I(1,0,32'h0,1,0,0,0));    tex.push_back(O(1,0,0,0, 1,0,32'h1000, 1,0,0,32'h0, 1,0));
        tin.push_back(I(1,1,32'h1040,1,0,0,0)); tex.push_back(O(1,1,0,0, 0,0,32'h1000, 1,0,0,32'h0, 1,0));
        for (int k = 2; k < 8; k++) begin
            tin.push_back(I(1,1,32'h1000 + 32'(k)*32'h40,1,0,0,0));
            tex.push_back(O(1,1,0,0, 1,3'(k-1),32'h1000 + 32'(k-1)*32'h40, 1,0,0,32'h0, 4'(k),0));
        end
        tin.push_back(I(1,1,32'h2000,1,0,0,0)); tex.push_back(O(0,0,0,0, 1,7,32'h11C0, 1,0,0,32'h0, 8,0));
        tin.push_back(I(1,1,32'h2000,1,0,0,0)); tex.push_back(O(0,0,0,0, 0,7,32'h11C0, 1,0,0,32'h0, 8,0));
        tin.push_back(I(1,1,32'h2000,1,1,3,0)); tex.push_back(O(0,0,0,0, 0,7,32'h11C0, 1,0,0,32'h0, 8,0));
        for (int k = 0; k < 4; k++) begin
            tin.push_back(I(1,1,32'h2000,1,0,0,0)); tex.push_back(O(0,0,0,0, 0,7,32'h11C0, 0,1,3,32'h10C0, 8,0));
        end
        tin.push_back(I(1,1,32'h2000,1,0,0,1)); tex.push_back(O(0,0,0,0, 0,7,32'h11C0, 0,1,3,32'h10C0, 8,0));
        tin.push_back(I(1,1,32'h2000,1,0,0,0)); tex.push_back(O(0,0,1,3, 0,7,32'h11C0, 0,0,0,32'h0, 8,0));
        tin.push_back(I(1,1,32'h2000,1,0,0,0)); tex.push_back(O(1,1,0,0, 0,7,32'h11C0, 1,0,0,32'h0, 7,0));
        for (int k = 0; k < 3; k++) begin
            tin.push_back(I(1,0,32'h0,0,0,0,0)); tex.push_back(O(0,0,0,0, 1,3,32'h2000, 1,0,0,32'h0, 8,0));
        end
        tin.push_back(I(0,1,32'h2000,1,0,0,0)); tex.push_back(O(0,0,0,0, 1,3,32'h2000, 0,0,0,32'h0, 8,0));
        tin.push_back(I(0,0,32'h0,1,1,0,0));    tex.push_back(O(0,0,0,0, 1,3,32'h2000, 0,0,0,32'h0, 8,0));
        tin.push_back(I(1,0,32'h0,1,0,0,0));    tex.push_back(O(0,0,0,0, 1,3,32'h2000, 1,0,0,32'h0, 8,0));
        tin.push_back(I(1,0,32'h0,1,0,0,0));    tex.push_back(O(0,0,0,0, 0,3,32'h2000, 1,0,0,32'h0, 8,0));
        for (int r = 0; r < tin.size(); r++) step($sformatf("table_row%0d", r), tin[r], tex[r]);

        // unknown-tag response: sticky error, no push, stays ready for responses
        do_reset();
        drive(I(1,0,32'h0,0,1,5,0)); #1;
        chk("unk_rsp_ready", bus.mem_rsp_ready, 1'b1);
        cycle();
        drive(I(1,0,32'h0,0,0,0,0)); #1;
        chk("unk_err_set", bus.err_unknown_tag, 1'b1);
        chk("unk_no_push", bus.push, 1'b0);
        chk("unk_still_idle", bus.mem_rsp_ready, 1'b1);
        cycle();
        drive(I(1,0,32'h0,0,0,0,0)); #1;
        chk("unk_err_sticky", {bus.err_unknown_tag, bus.outstanding}, {1'b1, 4'd0});
        cycle();

        // stall during FILL, then reset mid-FILL
        step("fill_accept", I(1,1,32'h3000,1,0,0,0), O(1,1,0,0, 0,0,32'h0, 1,0,0,32'h0, 0,1));
        step("fill_req",    I(1,0,32'h0,1,1,0,0),    O(1,0,0,0, 1,0,32'h3000, 1,0,0,32'h0, 1,1));
        step("fill_stall1", I(0,0,32'h0,1,0,0,1),    O(0,0,0,0, 0,0,32'h3000, 0,1,0,32'h3000, 1,1));
        step("fill_stall2", I(0,0,32'h0,1,0,0,1),    O(0,0,0,0, 0,0,32'h3000, 0,1,0,32'h3000, 1,1));
        do_reset();
        step("post_rst_miss", I(1,1,32'h4000,1,0,0,0), O(1,1,0,0, 0,0,32'h0, 1,0,0,32'h0, 0,0));
        step("post_rst_req",  I(1,0,32'h0,1,0,0,0),    O(1,0,0,0, 1,0,32'h4000, 1,0,0,32'h0, 1,0));

        // random phase against the reference model
        do_reset();
        for (int t = 0; t < 8; t++) begin m_pend[t] = 0; m_addr[t] = '0; end
        memq = {}; m_rqv = 0; m_rqt = 0; m_rqa = 0; m_ph = 0; m_cur = 0;
        m_outs = 0; m_err = 0; m_alloc = 0; m_stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ri;
            logic ftv, old_pend;
            logic [2:0] ft;
            ri = -1;
            v.en  = ($urandom_range(0, 9) != 0);
            v.mv  = 1'($urandom_range(0, 1));
            v.ma  = $urandom;
            v.mrr = ($urandom_range(0, 3) != 0);
            v.fr  = ($urandom_range(0, 2) != 0);
            v.rv  = 0; v.rt = 0;
            if (memq.size() > 0 && $urandom_range(0, 1) == 1) begin
                ri = $urandom_range(0, memq.size() - 1);
                v.rv = 1; v.rt = memq[ri];
            end else if (cyc > 2700 && $urandom_range(0, 19) == 0) begin
                logic [2:0] t;
                t = 3'($urandom_range(0, 7));
                if (!m_pend[t]) begin v.rv = 1; v.rt = t; end
            end
            ftv = (fl.size() > 0);
            ft  = ftv ? fl[0] : 3'd0;
            e.mr   = v.en & ftv & (!m_rqv | v.mrr);
            e.pop  = v.mv & e.mr;
            e.push = v.en && (m_ph == 2);
            e.ptag = e.push ? m_cur : 3'd0;
            e.rqv  = m_rqv; e.rqt = m_rqt; e.rqa = m_rqa;
            e.rsr  = v.en && (m_ph == 0);
            e.fv   = (m_ph == 1);
            e.ftag = e.fv ? m_cur : 3'd0;
            e.fa   = e.fv ? m_addr[m_cur] : 32'h0;
            e.outs = 4'(m_outs);
            e.err  = m_err;
            step($sformatf("rand_cyc%0d", cyc), v, e);

            old_pend = m_pend[v.rt];
            if (v.en && m_ph == 0 && v.rv) begin
                if (old_pend) begin
                    m_ph = 1; m_cur = v.rt;
                    if (ri >= 0) memq.delete(ri);
                end else m_err = 1;
            end else if (v.en && m_ph == 1) begin
                if (v.fr) m_ph = 2;
            end else if (v.en && m_ph == 2) m_ph = 0;
            if (e.push) m_pend[e.ptag] = 0;
            if (e.pop) begin m_pend[ft] = 1; m_addr[ft] = v.ma; end
            if (v.en && m_rqv && v.mrr) memq.push_back(m_rqt);
            if (v.en) begin
                if (e.pop) begin m_rqv = 1; m_rqt = ft; m_rqa = v.ma; end
                else if (v.mrr) m_rqv = 0;
            end
            m_outs = m_outs + int'(e.pop) - int'(e.push);
            if (e.pop) m_alloc++;
            if (v.en && v.mv && !e.mr) m_stall++;
        end
`ifdef MISS_ALLOC_STATS_EN
        chk("alloc_count", bus.alloc_count, 32'(m_alloc));
        chk("stall_count", bus.stall_count, 32'(m_stall));
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
